// File: rtl/sequence_detector_mealy.sv
// Serial-bit Mealy sequence detector.
// Flags every occurrence of PATTERN (MSB arrives first) in the serial stream on x.
// The state is the length of the longest pattern prefix that is a suffix of the
// bits seen so far. All transitions, including the KMP fallbacks, come from a
// table that is built when the design is elaborated.
module sequence_detector_mealy #(
    parameter int unsigned                PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0]     PATTERN     = 4'b1101,
    parameter bit                         OVERLAP     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    localparam int          PLEN = int'(PATTERN_LEN);
    localparam int unsigned SW   = (PATTERN_LEN > 1) ? $clog2(PATTERN_LEN) : 1;
    localparam int unsigned NENT = 2 ** (SW + 1);

    localparam logic [SW-1:0] LAST_STATE = SW'(PATTERN_LEN - 1);
    localparam logic          LAST_BIT   = PATTERN[0];

    // One next-state entry per {state, x}; unused encodings stay 0.
    typedef logic [NENT-1:0][SW-1:0] table_t;

    // Pattern bit number k in arrival order (k = 0 is the MSB).
    function automatic logic pat_bit(input int k);
        logic [31:0] sh;
        sh = 32'(PATTERN) >> (PLEN - 1 - k);
        return sh[0];
    endfunction

    // Bit i of the string made of the accepted prefix of length st followed by b.
    function automatic logic seq_bit(input int i, input int st, input logic b);
        return (i < st) ? pat_bit(i) : b;
    endfunction

    // Next prefix length after state st consumes bit b.
    function automatic int next_of(input int st, input logic b);
        int   res;
        int   kmax;
        logic ok;
        res = 0;
        if ((b == pat_bit(st)) && (st < PLEN - 1)) begin
            res = st + 1;
        end else if ((b == pat_bit(st)) && !OVERLAP) begin
            res = 0;
        end else begin
            // Longest border of (prefix st, b) that is shorter than the whole pattern.
            kmax = (st + 1 < PLEN - 1) ? (st + 1) : (PLEN - 1);
            for (int k = 1; k <= kmax; k++) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (pat_bit(j) != seq_bit(st + 1 - k + j, st, b)) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    res = k;
                end
            end
        end
        return res;
    endfunction

    // Fill every reachable {state, x} entry; unreachable states fall back to 0.
    function automatic table_t build_table();
        table_t      t;
        logic [SW:0] idx;
        t = '0;
        for (int st = 0; st < PLEN; st++) begin
            for (int b = 0; b < 2; b++) begin
                idx    = (SW + 1)'(2 * st + b);
                t[idx] = SW'(next_of(st, b[0]));
            end
        end
        return t;
    endfunction

    localparam table_t NEXT_TABLE = build_table();

    logic [SW-1:0] s;
    logic [SW-1:0] s_next;

    // State register: cleared asynchronously, advances one bit per rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s <= '0;
        end else begin
            s <= s_next;
        end
    end

    // Next state from the precomputed table; match flag from state and x.
    always_comb begin
        s_next = NEXT_TABLE[{s, x}];
        y      = 1'b0;
        if ((s == LAST_STATE) && (x == LAST_BIT)) begin
            y = 1'b1;
        end
    end

endmodule

// File: tb/tb_sequence_detector_mealy.sv
// Directed testbench for sequence_detector_mealy: default pattern with and
// without overlap, asynchronous reset behaviour, and a 3-bit pattern variant.
module tb_sequence_detector_mealy;

    logic clk = 1'b0;
    logic reset;
    logic x_def, x_nov, x_alt;
    logic y_def, y_nov, y_alt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sequence_detector_mealy dut_def (
        .clk   (clk),
        .reset (reset),
        .x     (x_def),
        .y     (y_def)
    );

    sequence_detector_mealy #(
        .PATTERN_LEN (4),
        .PATTERN     (4'b1101),
        .OVERLAP     (1'b0)
    ) dut_nov (
        .clk   (clk),
        .reset (reset),
        .x     (x_nov),
        .y     (y_nov)
    );

    sequence_detector_mealy #(
        .PATTERN_LEN (3),
        .PATTERN     (3'b010),
        .OVERLAP     (1'b1)
    ) dut_alt (
        .clk   (clk),
        .reset (reset),
        .x     (x_alt),
        .y     (y_alt)
    );

    // Count one comparison and report it if the observed value differs.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_y(input int inst);
        case (inst)
            0:       return 32'(y_def);
            1:       return 32'(y_nov);
            default: return 32'(y_alt);
        endcase
    endfunction

    function automatic logic [31:0] get_s(input int inst);
        case (inst)
            0:       return 32'(dut_def.s);
            1:       return 32'(dut_nov.s);
            default: return 32'(dut_alt.s);
        endcase
    endfunction

    // Present one bit mid-low-phase, check y before the edge and s after it.
    task automatic apply_bit(input int inst, input logic b, input logic ey,
                             input int es, input string tag);
        @(negedge clk);
        #2;
        case (inst)
            0:       x_def = b;
            1:       x_nov = b;
            default: x_alt = b;
        endcase
        #1;
        check({tag, "_y"}, get_y(inst), 32'(ey));
        @(posedge clk);
        #1;
        check({tag, "_s"}, get_s(inst), 32'(es));
    endtask

    // Pulse reset between edges and release it before a rising edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        x_def = 1'b0;
        x_nov = 1'b0;
        x_alt = 1'b0;
        #1;
        check("rst_s_def", get_s(0), 32'd0);
        check("rst_s_nov", get_s(1), 32'd0);
        check("rst_s_alt", get_s(2), 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
    endtask

    logic mix_x [15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int   mix_s [15] = '{0, 0, 1, 2, 2, 3, 0, 0, 1, 2, 3, 1, 2, 2, 3};

    logic ovl_x [7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic ovl_y [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    int   ovl_s [7]  = '{1, 2, 3, 1, 2, 3, 1};
    logic nov_y [7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int   nov_s [7]  = '{1, 2, 3, 0, 1, 0, 1};

    logic alt_x [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic alt_y [5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   alt_s [5]  = '{1, 2, 1, 2, 1};

    initial begin
        reset = 1'b1;
        x_def = 1'b0;
        x_nov = 1'b0;
        x_alt = 1'b0;

        // Reset held with x toggling: y and s stay 0.
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #2;
            x_def = ~x_def;
            x_alt = ~x_alt;
            #1;
            check($sformatf("hold_rst_y%0d", i), get_y(0), 32'd0);
            check($sformatf("hold_rst_yalt%0d", i), get_y(2), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("hold_rst_s%0d", i), get_s(0), 32'd0);
        end
        @(negedge clk);
        #2;
        x_def = 1'b0;
        x_alt = 1'b0;
        reset = 1'b0;

        // Mixed stream: single match on bit 12.
        for (int i = 0; i < 15; i++) begin
            apply_bit(0, mix_x[i], (i == 11), mix_s[i], $sformatf("mix_b%0d", i + 1));
        end

        // Overlapping matches.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_bit(0, ovl_x[i], ovl_y[i], ovl_s[i], $sformatf("ovl_b%0d", i + 1));
        end

        // Same stream without overlap.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            apply_bit(1, ovl_x[i], nov_y[i], nov_s[i], $sformatf("nov_b%0d", i + 1));
        end

        // Asynchronous reset in the middle of a partial match.
        do_reset();
        apply_bit(0, 1'b1, 1'b0, 1, "arst_b1");
        apply_bit(0, 1'b1, 1'b0, 2, "arst_b2");
        apply_bit(0, 1'b0, 1'b0, 3, "arst_b3");
        @(negedge clk);
        #1;
        x_def = 1'b1;
        reset = 1'b1;
        #1;
        check("arst_now_s", get_s(0), 32'd0);
        check("arst_now_y", get_y(0), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        check("arst_rel_s", get_s(0), 32'd0);
        @(posedge clk);
        #1;
        check("arst_edge_s", get_s(0), 32'd1);
        apply_bit(0, 1'b1, 1'b0, 2, "arst_c1");
        apply_bit(0, 1'b0, 1'b0, 3, "arst_c2");
        apply_bit(0, 1'b1, 1'b1, 1, "arst_c3");

        // Three-bit pattern 010 with overlap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply_bit(2, alt_x[i], alt_y[i], alt_s[i], $sformatf("alt_b%0d", i + 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
